minitb_ahb_slave: RTL and testbench
===================================

MINITB_AHB_SLAVE -- requirements
Module: minitb_ahb_slave

Interface
REQ-001 SHALL have parameter addrWidth, default 8, meaning address bus width.
REQ-002 SHALL have parameter dataWidth, default 32, meaning data bus width; legal values are 32 only.
REQ-003 SHALL have parameter memBytes, default 128, meaning backing-store size in bytes (multiple of 4, <= 2**addrWidth).
REQ-004 SHALL have parameter waitStates, default 0, meaning wait cycles inserted per OKAY data phase (0..15).
REQ-005 SHALL have port hclk, input, 1, meaning the single clock.
REQ-006 SHALL have port hresetn, input, 1, meaning reset; synchronous, active-low.
REQ-007 SHALL have ports hsel (in 1), htrans (in 2), haddr (in addrWidth), hwrite (in 1), hsize (in 3), hburst (in 3, ignored), hready (in 1, bus-level ready), hwdata (in dataWidth).
REQ-008 SHALL have outputs hreadyout (1), hresp (2, OKAY=00, ERROR=01), hrdata (dataWidth).

Function
REQ-009 SHALL accept an address phase on a rising edge when hsel=1, hready=1 and htrans is NONSEQ(10) or SEQ(11), latching haddr/hwrite/hsize.
REQ-010 SHALL treat IDLE(00)/BUSY(01), or hsel=0, as no transfer: next data phase is hreadyout=1, hresp=OKAY.
REQ-011 SHALL flag an accepted transfer as error when haddr >= memBytes, hsize > 2 (word), or haddr unaligned to hsize.
REQ-012 SHALL use FSM states IDLE, WAIT, ERR1, ERR2.
REQ-013 SHALL transition on a good transfer to WAIT when waitStates>0 (hreadyout=0, OKAY, down-counter loaded waitStates-1), else stay IDLE with hreadyout=1 in the data phase.
REQ-014 SHALL in WAIT hold hreadyout=0 until counter reaches 0, then return to IDLE driving hreadyout=1, OKAY (data phase length exactly waitStates+1 cycles).
REQ-015 SHALL on an error transfer drive ERR1 (hreadyout=0, hresp=ERROR) then ERR2 (hreadyout=1, hresp=ERROR), then IDLE; no memory write, hrdata=0.
REQ-016 SHALL commit writes at the final (hreadyout=1) data-phase edge using hwdata lanes selected by haddr[1:0] and hsize (byte: 1 lane, halfword: 2 lanes, word: 4 lanes); other bytes unchanged.
REQ-017 SHALL drive hrdata in the final data-phase cycle with the full aligned word at haddr[addrWidth-1:2]; hrdata=0 outside read data phases.
REQ-018 SHALL forward a write committing on the same edge to a pipelined read of the same word (write-then-read back-to-back returns new data).
REQ-019 SHALL pipeline: the address phase of transfer N+1 is accepted on the edge that completes data phase N (hready=1).
REQ-020 SHALL ignore hburst; each beat is decoded independently.

Reset
REQ-021 SHALL, when hresetn=0 at a rising edge, set state IDLE, counter 0, hreadyout=1, hresp=OKAY, hrdata=0, and clear any latched transfer.
REQ-022 SHALL abandon an in-progress data phase on reset without committing its write.
REQ-023 SHALL NOT initialise the backing store on reset.

Structure
REQ-024 SHALL take htrans, hresp, hsize enums and the FSM state typedef from shared package minitb_ahb_pkg.
REQ-025 SHALL place the byte-lane RAM in sub-module minitb_ahb_slave_mem (one write port with 4 byte enables, one async read port).

Verification
REQ-026 waitStates=0: word write 0xDEADBEEF @0x10 then back-to-back read @0x10 -> read data phase 1 cycle, hrdata=0xDEADBEEF, OKAY.
REQ-027 waitStates=3: word read @0x04 -> hreadyout low 3 cycles, high on 4th, OKAY.
REQ-028 byte write 0xAA to 0x21 over word 0x11223344 @0x20, read @0x20 -> hrdata=0x1122AA44.
REQ-029 read @0x80 (memBytes=128) -> ERR1 (hreadyout=0, ERROR), ERR2 (hreadyout=1, ERROR); halfword write @0x03 -> same, memory unchanged.
REQ-030 hresetn=0 during WAIT of a write @0x08 (waitStates=2) -> next cycle hreadyout=1, OKAY; later read @0x08 returns prior contents.
REQ-031 IDLE and BUSY htrans with hsel=1 -> hreadyout=1, OKAY, no memory change.

Source files
------------

// File: rtl/minitb_ahb_pkg.sv
// Shared AHB-lite encodings, slave FSM states and the latched data-phase
// descriptor used by the minitb AHB slave.
package minitb_ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01
    } hresp_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'd0,
        HSIZE_HALF = 3'd1,
        HSIZE_WORD = 3'd2
    } hsize_e;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_WAIT = 2'd1;
    localparam state_t ST_ERR1 = 2'd2;
    localparam state_t ST_ERR2 = 2'd3;

    // Only good transfers are latched; errors live entirely in the FSM.
    typedef struct packed {
        logic       valid;
        logic       write;
        logic [2:0] size;
    } xfer_t;

    function automatic logic [3:0] lane_en(input logic [1:0] lane, input logic [2:0] size);
        case (size)
            HSIZE_BYTE: return 4'b0001 << lane;
            HSIZE_HALF: return 4'b0011 << lane;
            default:    return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/minitb_ahb_slave_mem.sv
// Byte-lane backing store: one synchronous write port with per-byte enables,
// one asynchronous word read port. Contents are never reset.
module minitb_ahb_slave_mem #(
    parameter int words     = 32,
    parameter int idxWidth  = 5,
    parameter int dataWidth = 32
) (
    input  logic                 hclk,
    input  logic                 we,
    input  logic [3:0]           be,
    input  logic [idxWidth-1:0]  waddr,
    input  logic [dataWidth-1:0] wdata,
    input  logic [idxWidth-1:0]  raddr,
    output logic [dataWidth-1:0] rdata
);

    for (genvar i = 0; i < 4; i++) begin : g_lane
        logic [7:0] lane_q [words];

        always_ff @(posedge hclk) begin
            if (we && be[i])
                lane_q[waddr] <= wdata[8*i +: 8];
        end

        assign rdata[8*i +: 8] = lane_q[raddr];
    end

endmodule

// File: rtl/minitb_ahb_slave.sv
// AHB-lite memory slave with configurable OKAY wait states, two-cycle ERROR
// response and pipelined address/data phases.
module minitb_ahb_slave
    import minitb_ahb_pkg::*;
#(
    parameter int addrWidth  = 8,
    parameter int dataWidth  = 32,
    parameter int memBytes   = 128,
    parameter int waitStates = 0
) (
    input  logic                 hclk,
    input  logic                 hresetn,
    input  logic                 hsel,
    input  logic [1:0]           htrans,
    input  logic [addrWidth-1:0] haddr,
    input  logic                 hwrite,
    input  logic [2:0]           hsize,
    input  logic [2:0]           hburst,
    input  logic                 hready,
    input  logic [dataWidth-1:0] hwdata,
    output logic                 hreadyout,
    output logic [1:0]           hresp,
    output logic [dataWidth-1:0] hrdata
);

    localparam int WORDS = memBytes / 4;
    localparam int IDXW  = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [addrWidth:0] MEM_LIMIT = (addrWidth+1)'(memBytes);
    localparam logic [3:0] WS_LOAD = 4'((waitStates > 0) ? waitStates - 1 : 0);

    state_t               state;
    logic [3:0]           cnt;
    xfer_t                dp;
    logic [addrWidth-1:0] dp_addr;

    logic                 done, accept, bad, we, final_rd;
    logic [3:0]           be;
    logic [dataWidth-1:0] rdata;

    // A data phase completes on any edge where we present hreadyout=1.
    assign done      = (state == ST_IDLE) || (state == ST_ERR2);
    assign hreadyout = done;
    assign hresp     = ((state == ST_ERR1) || (state == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;

    assign accept = hsel && hready && done &&
                    ((htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ));

    assign bad = ({1'b0, haddr} >= MEM_LIMIT) ||
                 (hsize > HSIZE_WORD) ||
                 ((hsize == HSIZE_HALF) && haddr[0]) ||
                 ((hsize == HSIZE_WORD) && (haddr[1:0] != 2'b00));

    // Writes land on the completing edge, so a read accepted on that same edge
    // sees the new word through the async read port one cycle later.
    assign we       = hresetn && dp.valid && dp.write && (state == ST_IDLE);
    assign final_rd = dp.valid && !dp.write && (state == ST_IDLE);
    assign be       = lane_en(dp_addr[1:0], dp.size);
    assign hrdata   = final_rd ? rdata : '0;

    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            dp      <= '0;
            dp_addr <= '0;
        end else begin
            case (state)
                ST_WAIT: begin
                    if (cnt == 4'd0)
                        state <= ST_IDLE;
                    else
                        cnt <= cnt - 4'd1;
                end
                ST_ERR1: state <= ST_ERR2;
                default: begin
                    dp <= '0;
                    if (accept) begin
                        dp_addr <= haddr;
                        if (bad) begin
                            state <= ST_ERR1;
                        end else begin
                            dp    <= '{valid: 1'b1, write: hwrite, size: hsize};
                            state <= (waitStates > 0) ? ST_WAIT : ST_IDLE;
                            cnt   <= WS_LOAD;
                        end
                    end else begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    minitb_ahb_slave_mem #(
        .words    (WORDS),
        .idxWidth (IDXW),
        .dataWidth(dataWidth)
    ) u_mem (
        .hclk (hclk),
        .we   (we),
        .be   (be),
        .waddr(dp_addr[IDXW+1:2]),
        .wdata(hwdata),
        .raddr(dp_addr[IDXW+1:2]),
        .rdata(rdata)
    );

    logic unused_ok;
    assign unused_ok = ^{hburst, dp_addr};

endmodule

// File: tb/tb_minitb_ahb_slave.sv
// Directed bench: three slaves (0, 2 and 3 wait states) on one shared bus.
module tb_minitb_ahb_slave;

    logic        hclk = 1'b0;
    logic        hresetn;
    logic        sel;
    int          cur;
    logic [1:0]  htrans;
    logic [7:0]  haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic        hready;
    logic [31:0] hwdata;

    logic        hsel0, hsel2, hsel3;
    logic        ro0, ro2, ro3;
    logic [1:0]  rsp0, rsp2, rsp3;
    logic [31:0] rd0, rd2, rd3;
    logic        ro_s;
    logic [1:0]  rsp_s;
    logic [31:0] rd_s;

    int n_chk = 0;
    int n_fail = 0;

    always #5 hclk = ~hclk;

    assign hready = ro0 & ro2 & ro3;
    assign hsel0  = sel && (cur == 0);
    assign hsel2  = sel && (cur == 2);
    assign hsel3  = sel && (cur == 3);
    assign ro_s   = (cur == 0) ? ro0  : (cur == 2) ? ro2  : ro3;
    assign rsp_s  = (cur == 0) ? rsp0 : (cur == 2) ? rsp2 : rsp3;
    assign rd_s   = (cur == 0) ? rd0  : (cur == 2) ? rd2  : rd3;

    minitb_ahb_slave #(.addrWidth(8), .dataWidth(32), .memBytes(128), .waitStates(0)) u_ws0 (
        .hclk(hclk), .hresetn(hresetn), .hsel(hsel0), .htrans(htrans), .haddr(haddr),
        .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hready(hready), .hwdata(hwdata),
        .hreadyout(ro0), .hresp(rsp0), .hrdata(rd0));

    minitb_ahb_slave #(.addrWidth(8), .dataWidth(32), .memBytes(128), .waitStates(2)) u_ws2 (
        .hclk(hclk), .hresetn(hresetn), .hsel(hsel2), .htrans(htrans), .haddr(haddr),
        .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hready(hready), .hwdata(hwdata),
        .hreadyout(ro2), .hresp(rsp2), .hrdata(rd2));

    minitb_ahb_slave #(.addrWidth(8), .dataWidth(32), .memBytes(128), .waitStates(3)) u_ws3 (
        .hclk(hclk), .hresetn(hresetn), .hsel(hsel3), .htrans(htrans), .haddr(haddr),
        .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hready(hready), .hwdata(hwdata),
        .hreadyout(ro3), .hresp(rsp3), .hrdata(rd3));

    task automatic step();
        @(posedge hclk);
        #1;
    endtask

    task automatic bus_idle();
        sel    = 1'b0;
        htrans = 2'b00;
        hwrite = 1'b0;
        haddr  = 8'h00;
        hsize  = 3'd2;
        hburst = 3'd0;
    endtask

    // Runs one isolated transfer and reports what the slave showed.
    task automatic xfer(input int dut, input logic w, input logic [7:0] a, input logic [2:0] sz,
                        input logic [31:0] wd, output int lows, output logic [1:0] r_first,
                        output logic [1:0] r_last, output logic [31:0] rdat);
        cur = dut; sel = 1'b1; htrans = 2'b10; hwrite = w; haddr = a; hsize = sz; hburst = 3'b001;
        step();
        bus_idle();
        hwdata  = wd;
        lows    = 0;
        r_first = rsp_s;
        while (ro_s !== 1'b1 && lows < 32) begin
            lows++;
            step();
        end
        r_last = rsp_s;
        rdat   = rd_s;
        step();
        hwdata = '0;
    endtask

    task automatic test_reset();
        hresetn = 1'b0;
        hwdata  = '0;
        bus_idle();
        step();
        step();
        for (int d = 0; d <= 3; d++) begin
            if (d == 1) continue;
            cur = d;
            n_chk++;
            if (ro_s !== 1'b1 || rsp_s !== 2'b00 || rd_s !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_dut%0d: got ro=%b rsp=%b rd=%h, expected ro=1 rsp=00 rd=0", d, ro_s, rsp_s, rd_s);
            end
        end
        hresetn = 1'b1;
        step();
    endtask

    task automatic test_back_to_back();
        int lows;
        cur = 0; sel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 8'h10; hsize = 3'd2;
        step();
        hwrite = 1'b0; hwdata = 32'hDEADBEEF;
        n_chk++;
        if (ro_s !== 1'b1) begin n_fail++; $display("FAIL b2b_wr_ready: got %b expected 1", ro_s); end
        step();
        bus_idle(); hwdata = '0;
        n_chk++;
        if (ro_s !== 1'b1 || rsp_s !== 2'b00) begin
            n_fail++; $display("FAIL b2b_rd_phase: got ro=%b rsp=%b expected ro=1 rsp=00", ro_s, rsp_s);
        end
        n_chk++;
        if (rd_s !== 32'hDEADBEEF) begin n_fail++; $display("FAIL b2b_rd_data: got %h expected deadbeef", rd_s); end
        step();
        n_chk++;
        if (rd_s !== 32'h0) begin n_fail++; $display("FAIL b2b_rd_idle: got %h expected 0", rd_s); end

        // Read presented while the write waits must only be taken when it completes.
        cur = 3; sel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 8'h0C; hsize = 3'd2;
        step();
        hwrite = 1'b0; hwdata = 32'h01020304;
        lows = 0;
        while (ro_s !== 1'b1 && lows < 32) begin lows++; step(); end
        n_chk++;
        if (lows != 3) begin n_fail++; $display("FAIL pipe_wr_waits: got %0d expected 3", lows); end
        step();
        bus_idle(); hwdata = '0;
        lows = 0;
        while (ro_s !== 1'b1 && lows < 32) begin lows++; step(); end
        n_chk++;
        if (lows != 3) begin n_fail++; $display("FAIL pipe_rd_waits: got %0d expected 3", lows); end
        n_chk++;
        if (rd_s !== 32'h01020304 || rsp_s !== 2'b00) begin
            n_fail++; $display("FAIL pipe_rd_data: got rd=%h rsp=%b expected 01020304 00", rd_s, rsp_s);
        end
        step();
    endtask

    task automatic test_wait_states();
        int lows; logic [1:0] rf, rl; logic [31:0] rd;
        xfer(3, 1'b1, 8'h04, 3'd2, 32'h0BADF00D, lows, rf, rl, rd);
        n_chk++;
        if (lows != 3) begin n_fail++; $display("FAIL ws3_wr_waits: got %0d expected 3", lows); end
        xfer(3, 1'b0, 8'h04, 3'd2, 32'h0, lows, rf, rl, rd);
        n_chk++;
        if (lows != 3 || rf !== 2'b00 || rl !== 2'b00) begin
            n_fail++; $display("FAIL ws3_rd_timing: got waits=%0d resp=%b/%b expected 3 00/00", lows, rf, rl);
        end
        n_chk++;
        if (rd !== 32'h0BADF00D) begin n_fail++; $display("FAIL ws3_rd_data: got %h expected 0badf00d", rd); end
    endtask

    task automatic test_byte_lanes();
        int lows; logic [1:0] rf, rl; logic [31:0] rd;
        xfer(0, 1'b1, 8'h20, 3'd2, 32'h11223344, lows, rf, rl, rd);
        xfer(0, 1'b1, 8'h21, 3'd0, 32'h0000AA00, lows, rf, rl, rd);
        xfer(0, 1'b0, 8'h20, 3'd2, 32'h0, lows, rf, rl, rd);
        n_chk++;
        if (rd !== 32'h1122AA44) begin n_fail++; $display("FAIL byte_write: got %h expected 1122aa44", rd); end
        xfer(0, 1'b1, 8'h22, 3'd1, 32'hBEEF0000, lows, rf, rl, rd);
        xfer(0, 1'b0, 8'h20, 3'd2, 32'h0, lows, rf, rl, rd);
        n_chk++;
        if (rd !== 32'hBEEFAA44) begin n_fail++; $display("FAIL half_write: got %h expected beefaa44", rd); end
    endtask

    task automatic test_errors();
        int lows; logic [1:0] rf, rl; logic [31:0] rd;
        xfer(0, 1'b0, 8'h80, 3'd2, 32'h0, lows, rf, rl, rd);
        n_chk++;
        if (lows != 1 || rf !== 2'b01 || rl !== 2'b01 || rd !== 32'h0) begin
            n_fail++; $display("FAIL err_range: got waits=%0d resp=%b/%b rd=%h expected 1 01/01 0", lows, rf, rl, rd);
        end
        xfer(0, 1'b1, 8'h00, 3'd2, 32'h55667788, lows, rf, rl, rd);
        xfer(0, 1'b1, 8'h03, 3'd1, 32'hFFFFFFFF, lows, rf, rl, rd);
        n_chk++;
        if (lows != 1 || rf !== 2'b01 || rl !== 2'b01) begin
            n_fail++; $display("FAIL err_unaligned: got waits=%0d resp=%b/%b expected 1 01/01", lows, rf, rl);
        end
        xfer(0, 1'b1, 8'h00, 3'd3, 32'hFFFFFFFF, lows, rf, rl, rd);
        n_chk++;
        if (lows != 1 || rf !== 2'b01 || rl !== 2'b01) begin
            n_fail++; $display("FAIL err_size: got waits=%0d resp=%b/%b expected 1 01/01", lows, rf, rl);
        end
        xfer(0, 1'b0, 8'h00, 3'd2, 32'h0, lows, rf, rl, rd);
        n_chk++;
        if (rd !== 32'h55667788) begin n_fail++; $display("FAIL err_no_write: got %h expected 55667788", rd); end
    endtask

    task automatic test_reset_in_wait();
        int lows; logic [1:0] rf, rl; logic [31:0] rd;
        xfer(2, 1'b1, 8'h08, 3'd2, 32'h12345678, lows, rf, rl, rd);
        n_chk++;
        if (lows != 2) begin n_fail++; $display("FAIL ws2_waits: got %0d expected 2", lows); end
        cur = 2; sel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 8'h08; hsize = 3'd2;
        step();
        bus_idle(); hwdata = 32'hCAFEF00D;
        n_chk++;
        if (ro_s !== 1'b0) begin n_fail++; $display("FAIL rst_in_wait_pre: got %b expected 0", ro_s); end
        hresetn = 1'b0;
        step();
        n_chk++;
        if (ro_s !== 1'b1 || rsp_s !== 2'b00) begin
            n_fail++; $display("FAIL rst_in_wait: got ro=%b rsp=%b expected 1 00", ro_s, rsp_s);
        end
        hresetn = 1'b1; hwdata = '0;
        step();
        xfer(2, 1'b0, 8'h08, 3'd2, 32'h0, lows, rf, rl, rd);
        n_chk++;
        if (rd !== 32'h12345678) begin n_fail++; $display("FAIL rst_no_commit: got %h expected 12345678", rd); end
    endtask

    task automatic test_idle_busy();
        int lows; logic [1:0] rf, rl; logic [31:0] rd;
        logic [1:0] tr [3];
        logic       sl [3];
        tr[0] = 2'b00; sl[0] = 1'b1;
        tr[1] = 2'b01; sl[1] = 1'b1;
        tr[2] = 2'b10; sl[2] = 1'b0;
        xfer(0, 1'b1, 8'h30, 3'd2, 32'hA5A5A5A5, lows, rf, rl, rd);
        for (int i = 0; i < 3; i++) begin
            cur = 0; sel = sl[i]; htrans = tr[i]; hwrite = 1'b1; haddr = 8'h30; hsize = 3'd2;
            step();
            hwdata = '0;
            n_chk++;
            if (ro_s !== 1'b1 || rsp_s !== 2'b00) begin
                n_fail++; $display("FAIL notrans_%0d: got ro=%b rsp=%b expected 1 00", i, ro_s, rsp_s);
            end
        end
        bus_idle();
        step();
        xfer(0, 1'b0, 8'h30, 3'd2, 32'h0, lows, rf, rl, rd);
        n_chk++;
        if (rd !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL notrans_mem: got %h expected a5a5a5a5", rd); end
    endtask

    initial begin
        cur = 0;
        test_reset();
        test_back_to_back();
        test_wait_states();
        test_byte_lanes();
        test_errors();
        test_reset_in_wait();
        test_idle_busy();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
